commit_trace_buffer: RTL and testbench

Synthesizable retire-trace capture unit for the CPU core, replacing simulation-only trace logging. Each cycle it classifies one committed instruction (reg write, load, store, other, halt) and tags it with a sequence number. Records are queued in a parametrised FIFO that is drained over a valid/ready port to the debug/DMA path. Also provides cycle and instruction counters, sticky halt and watchdog timeout, and drop accounting.

---
 rtl/commit_trace_buffer.sv | 169 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies each committed instruction, queues tagged records
// in a FIFO drained over valid/ready, and keeps cycle/instruction/drop counters.
module commit_trace_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  inst,
  input  logic             reg_we,
  input  logic [4:0]       wr_reg,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             halt,
  input  logic [1:0]       filter_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_kind,
  output logic [CNT_W-1:0] out_inum,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [4:0]       out_reg,
  output logic [XLEN-1:0]  out_value,
  output logic [XLEN-1:0]  out_addr,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             halted,
  output logic             timeout
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    K_REG   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_OTHER = 3'd3,
    K_HALT  = 3'd4
  } kind_e;

  typedef struct packed {
    kind_e            kind;
    logic [CNT_W-1:0] inum;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [4:0]       rd;
    logic [XLEN-1:0]  value;
    logic [XLEN-1:0]  addr;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic             overflow_q, overflow_d, halted_q, halted_d, timeout_q, timeout_d;

  kind_e kind;
  rec_t  new_rec, head;
  logic  active, selected, room, push, pop, drop, halt_now, cycle_run;

  always_comb begin
    kind = K_OTHER;
    if (reg_we && mem_rd)  kind = K_LOAD;
    else if (reg_we)       kind = K_REG;
    else if (halt)         kind = K_HALT;
    else if (mem_wr)       kind = K_STORE;

    selected = 1'b0;
    case (filter_mode)
      2'd0:    selected = 1'b1;
      2'd1:    selected = (kind == K_REG);
      2'd2:    selected = (kind == K_LOAD) || (kind == K_STORE);
      default: selected = 1'b0;
    endcase
    if (kind == K_HALT) selected = 1'b1;

    new_rec       = '0;
    new_rec.kind  = kind;
    new_rec.inum  = inst_q;
    new_rec.pc    = pc;
    new_rec.inst  = inst;
    if (kind == K_REG || kind == K_LOAD) begin
      new_rec.rd    = wr_reg;
      new_rec.value = wr_data;
    end
    if (kind == K_STORE) new_rec.value = mem_data;
    if (kind == K_LOAD || kind == K_STORE) new_rec.addr = mem_addr;
  end

  always_comb begin
    active = commit_valid && !halted_q && !timeout_q;
    // The last slot is reserved so a HALT record can always be queued.
    room   = (kind == K_HALT) ? (occ_q < (AW+1)'(DEPTH)) : (occ_q < (AW+1)'(DEPTH - 1));
    push   = active && selected && room;
    drop   = active && selected && !room;
    pop    = (occ_q != '0) && out_ready;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);

    inst_d     = (active && inst_q != '1) ? inst_q + 1'b1 : inst_q;
    drop_d     = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    overflow_d = overflow_q || drop;

    halt_now  = active && (kind == K_HALT);
    halted_d  = halted_q || halt_now;
    cycle_run = !halted_q && !timeout_q;
    cycle_d   = (cycle_run && cycle_q != '1) ? cycle_q + 1'b1 : cycle_q;
    // Fires on the edge the count reaches TIMEOUT, so the count freezes there; halt wins a tie.
    timeout_d = timeout_q || (cycle_run && !halt_now && cycle_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  // Fields are forced to zero while empty so stale entries never leak after reset.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (occ_q != '0);
    out_kind  = out_valid ? head.kind  : 3'd0;
    out_inum  = out_valid ? head.inum  : '0;
    out_pc    = out_valid ? head.pc    : '0;
    out_inst  = out_valid ? head.inst  : '0;
    out_reg   = out_valid ? head.rd    : 5'd0;
    out_value = out_valid ? head.value : '0;
    out_addr  = out_valid ? head.addr  : '0;
  end

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a reference model queues expected records
// as commits are driven; a negedge monitor compares the FIFO head and counters.
module tb_commit_trace_buffer;
  localparam int XLEN = 32, DEPTH = 16, CNT_W = 32, TIMEOUT = 50;

  logic clk = 1'b0, rst = 1'b1;
  logic commit_valid = 0, reg_we = 0, mem_rd = 0, mem_wr = 0, halt = 0, out_ready = 0;
  logic [XLEN-1:0] pc = '0, inst = '0, wr_data = '0, mem_addr = '0, mem_data = '0;
  logic [4:0] wr_reg = '0;
  logic [1:0] filter_mode = '0;
  logic out_valid, overflow, halted, timeout;
  logic [2:0] out_kind;
  logic [4:0] out_reg;
  logic [CNT_W-1:0] out_inum, cycle_count, inst_count, drop_count;
  logic [XLEN-1:0] out_pc, out_inst, out_value, out_addr;

  always #5 clk = ~clk;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .inst(inst),
    .reg_we(reg_we), .wr_reg(wr_reg), .wr_data(wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt), .filter_mode(filter_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum),
    .out_pc(out_pc), .out_inst(out_inst), .out_reg(out_reg), .out_value(out_value),
    .out_addr(out_addr), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted), .timeout(timeout)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum, pc, inst;
    logic [4:0]  rd;
    logic [31:0] value, addr;
  } rec_t;

  int n_tests = 0, n_fail = 0;
  rec_t exp_q[$];
  rec_t pop_log[$];
  logic [31:0] m_cyc = 0, m_inst = 0, m_drop = 0;
  logic m_ovf = 0, m_halted = 0, m_timeout = 0;

  function automatic logic [2:0] classify(input logic rw, mr, mw, h);
    if (rw && mr) return 3'd1;
    if (rw) return 3'd0;
    if (h) return 3'd4;
    if (mw) return 3'd2;
    return 3'd3;
  endfunction

  function automatic bit wanted(input logic [1:0] mode, input logic [2:0] k);
    if (k == 3'd4) return 1;
    case (mode)
      2'd0: return 1;
      2'd1: return k == 3'd0;
      2'd2: return (k == 3'd1) || (k == 3'd2);
      default: return 0;
    endcase
  endfunction

  // Monitor + reference model: compare state after the last edge, then predict the next edge.
  always @(negedge clk) begin
    rec_t r;
    logic [2:0] k;
    int occ;
    bit act, push, pop, drop, hnow, inc;
    if (rst) begin
      exp_q.delete();
      m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_halted = 0; m_timeout = 0;
    end else begin
      n_tests++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL out_valid: got %0b want %0b", out_valid, exp_q.size() != 0);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        r = exp_q[0];
        n_tests++;
        if (out_kind !== r.kind || out_inum !== r.inum || out_pc !== r.pc || out_inst !== r.inst ||
            out_reg !== r.rd || out_value !== r.value || out_addr !== r.addr) begin
          n_fail++;
          $display("FAIL record: got k=%0d n=%0d pc=%h i=%h rd=%0d v=%h a=%h want k=%0d n=%0d pc=%h i=%h rd=%0d v=%h a=%h",
                   out_kind, out_inum, out_pc, out_inst, out_reg, out_value, out_addr,
                   r.kind, r.inum, r.pc, r.inst, r.rd, r.value, r.addr);
        end
      end
      n_tests++;
      if (cycle_count !== m_cyc || inst_count !== m_inst || drop_count !== m_drop ||
          overflow !== m_ovf || halted !== m_halted || timeout !== m_timeout) begin
        n_fail++;
        $display("FAIL counters: got cyc=%0d inst=%0d drop=%0d ovf=%0b h=%0b to=%0b want cyc=%0d inst=%0d drop=%0d ovf=%0b h=%0b to=%0b",
                 cycle_count, inst_count, drop_count, overflow, halted, timeout,
                 m_cyc, m_inst, m_drop, m_ovf, m_halted, m_timeout);
      end

      occ  = exp_q.size();
      pop  = (occ != 0) && out_ready;
      act  = commit_valid && !m_halted && !m_timeout;
      k    = classify(reg_we, mem_rd, mem_wr, halt);
      push = act && wanted(filter_mode, k) && ((k == 3'd4) ? (occ < DEPTH) : (occ < DEPTH - 1));
      drop = act && wanted(filter_mode, k) && (k != 3'd4) && (occ >= DEPTH - 1);
      if (pop) begin
        r = exp_q.pop_front();
        pop_log.push_back(r);
        $display("[TB] pop kind=%0d inum=%0d pc=%h value=%h addr=%h", r.kind, r.inum, r.pc, r.value, r.addr);
      end
      if (push) begin
        r.kind  = k;
        r.inum  = m_inst;
        r.pc    = pc;
        r.inst  = inst;
        r.rd    = (k <= 3'd1) ? wr_reg : 5'd0;
        r.value = (k <= 3'd1) ? wr_data : (k == 3'd2) ? mem_data : 32'd0;
        r.addr  = (k == 3'd1 || k == 3'd2) ? mem_addr : 32'd0;
        exp_q.push_back(r);
      end
      hnow = act && (k == 3'd4);
      inc  = !m_halted && !m_timeout && (m_cyc != 32'hFFFF_FFFF);
      if (inc && (m_cyc + 1 == TIMEOUT) && !hnow) m_timeout = 1;
      if (inc) m_cyc = m_cyc + 1;
      if (act && m_inst != 32'hFFFF_FFFF) m_inst = m_inst + 1;
      if (drop) begin
        m_drop = m_drop + 1;
        m_ovf = 1;
      end
      if (hnow) m_halted = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    commit_valid = 0;
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  task automatic commit(input logic rw, mr, mw, h, input logic [4:0] rg,
                        input logic [31:0] pc_i, wd, ma, md);
    commit_valid = 1; reg_we = rw; mem_rd = mr; mem_wr = mw; halt = h;
    wr_reg = rg; pc = pc_i; inst = pc_i ^ 32'h0000_0013;
    wr_data = wd; mem_addr = ma; mem_data = md;
    idle(1);
    commit_valid = 0; reg_we = 0; mem_rd = 0; mem_wr = 0; halt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (out_valid !== 0 || out_kind !== 0 || out_inum !== 0 || out_pc !== 0 || out_value !== 0 ||
        cycle_count !== 0 || inst_count !== 0 || drop_count !== 0 || overflow !== 0 ||
        halted !== 0 || timeout !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b cyc=%0d inst=%0d drop=%0d want all zero",
               out_valid, cycle_count, inst_count, drop_count);
    end
  endtask

  task automatic test_basic();
    int base;
    logic [2:0] kinds [4];
    kinds[0] = 3'd0; kinds[1] = 3'd1; kinds[2] = 3'd2; kinds[3] = 3'd4;
    do_reset();
    filter_mode = 0; out_ready = 1;
    base = pop_log.size();
    commit(1, 0, 0, 0, 5'd3, 32'h0, 32'h5, 32'h0, 32'h0);
    n_tests++;
    if (out_valid !== 1 || out_kind !== 3'd0 || out_inum !== 0) begin
      n_fail++;
      $display("FAIL basic_latency: got v=%0b k=%0d n=%0d want v=1 k=0 n=0", out_valid, out_kind, out_inum);
    end
    commit(1, 1, 0, 0, 5'd4, 32'h4, 32'h7, 32'h100, 32'h0);
    commit(0, 0, 1, 0, 5'd0, 32'h8, 32'h0, 32'h104, 32'h9);
    commit(0, 0, 0, 1, 5'd0, 32'hC, 32'h0, 32'h0, 32'h0);
    idle(3);
    n_tests++;
    if (inst_count !== 4 || halted !== 1 || pop_log.size() - base != 4) begin
      n_fail++;
      $display("FAIL basic_final: got inst=%0d halted=%0b pops=%0d want 4 1 4",
               inst_count, halted, pop_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (pop_log[base+i].kind !== kinds[i] || pop_log[base+i].inum !== i) begin
          n_fail++;
          $display("FAIL basic_order[%0d]: got k=%0d n=%0d want k=%0d n=%0d",
                   i, pop_log[base+i].kind, pop_log[base+i].inum, kinds[i], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    filter_mode = 0; out_ready = 0;
    for (int i = 0; i < 20; i++) commit(0, 0, 0, 0, 5'd0, 32'(i * 4), 32'h0, 32'h0, 32'h0);
    n_tests++;
    if (drop_count !== 5 || overflow !== 1 || inst_count !== 20 || out_valid !== 1) begin
      n_fail++;
      $display("FAIL bp_full: got drop=%0d ovf=%0b inst=%0d v=%0b want 5 1 20 1",
               drop_count, overflow, inst_count, out_valid);
    end
    commit(0, 0, 0, 1, 5'd0, 32'h50, 32'h0, 32'h0, 32'h0);
    n_tests++;
    if (inst_count !== 21 || halted !== 1 || drop_count !== 5) begin
      n_fail++;
      $display("FAIL bp_halt: got inst=%0d halted=%0b drop=%0d want 21 1 5", inst_count, halted, drop_count);
    end
    base = pop_log.size();
    out_ready = 1;
    idle(20);
    n_tests++;
    if (pop_log.size() - base != 16 || out_valid !== 0) begin
      n_fail++;
      $display("FAIL bp_drain: got pops=%0d v=%0b want 16 0", pop_log.size() - base, out_valid);
    end else begin
      n_tests++;
      if (pop_log[base+14].inum !== 14 || pop_log[base+15].inum !== 20 || pop_log[base+15].kind !== 3'd4) begin
        n_fail++;
        $display("FAIL bp_order: got n14=%0d n15=%0d k15=%0d want 14 20 4",
                 pop_log[base+14].inum, pop_log[base+15].inum, pop_log[base+15].kind);
      end
    end
  endtask

  task automatic test_filter();
    int base;
    logic [2:0] kinds [5];
    logic [31:0] inums [5];
    kinds[0] = 1; kinds[1] = 2; kinds[2] = 1; kinds[3] = 2; kinds[4] = 4;
    inums[0] = 1; inums[1] = 2; inums[2] = 4; inums[3] = 5; inums[4] = 7;
    do_reset();
    filter_mode = 2; out_ready = 1;
    base = pop_log.size();
    for (int j = 0; j < 2; j++) begin
      commit(1, 0, 0, 0, 5'd1, 32'(j * 12), 32'h11, 32'h0, 32'h0);
      commit(1, 1, 0, 0, 5'd2, 32'(j * 12 + 4), 32'h22, 32'h200, 32'h0);
      commit(0, 0, 1, 0, 5'd0, 32'(j * 12 + 8), 32'h0, 32'h204, 32'h33);
    end
    commit(1, 0, 0, 0, 5'd1, 32'h18, 32'h44, 32'h0, 32'h0);
    commit(0, 0, 0, 1, 5'd0, 32'h1C, 32'h0, 32'h0, 32'h0);
    idle(3);
    n_tests++;
    if (inst_count !== 8 || pop_log.size() - base != 5) begin
      n_fail++;
      $display("FAIL filter_count: got inst=%0d pops=%0d want 8 5", inst_count, pop_log.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (pop_log[base+i].kind !== kinds[i] || pop_log[base+i].inum !== inums[i]) begin
          n_fail++;
          $display("FAIL filter_order[%0d]: got k=%0d n=%0d want k=%0d n=%0d",
                   i, pop_log[base+i].kind, pop_log[base+i].inum, kinds[i], inums[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    filter_mode = 0; out_ready = 0;
    for (int i = 0; i < 15; i++) commit(0, 0, 0, 0, 5'd0, 32'(i * 4), 32'h0, 32'h0, 32'h0);
    n_tests++;
    if (drop_count !== 0 || out_valid !== 1) begin
      n_fail++;
      $display("FAIL pp_fill: got drop=%0d v=%0b want 0 1", drop_count, out_valid);
    end
    base = pop_log.size();
    out_ready = 1;
    commit(0, 0, 0, 0, 5'd0, 32'h3C, 32'h0, 32'h0, 32'h0);
    n_tests++;
    if (drop_count !== 1 || overflow !== 1 || inst_count !== 16) begin
      n_fail++;
      $display("FAIL pp_drop: got drop=%0d ovf=%0b inst=%0d want 1 1 16", drop_count, overflow, inst_count);
    end
    idle(16);
    n_tests++;
    if (pop_log.size() - base != 15 || out_valid !== 0 || pop_log[pop_log.size()-1].inum !== 14) begin
      n_fail++;
      $display("FAIL pp_drain: got pops=%0d v=%0b last=%0d want 15 0 14",
               pop_log.size() - base, out_valid, pop_log[pop_log.size()-1].inum);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    filter_mode = 0; out_ready = 0;
    idle(49);
    n_tests++;
    if (cycle_count !== 49 || timeout !== 0) begin
      n_fail++;
      $display("FAIL wd_before: got cyc=%0d to=%0b want 49 0", cycle_count, timeout);
    end
    idle(1);
    n_tests++;
    if (cycle_count !== 50 || timeout !== 1) begin
      n_fail++;
      $display("FAIL wd_fire: got cyc=%0d to=%0b want 50 1", cycle_count, timeout);
    end
    commit(1, 0, 0, 0, 5'd1, 32'h0, 32'h1, 32'h0, 32'h0);
    idle(3);
    n_tests++;
    if (cycle_count !== 50 || inst_count !== 0 || out_valid !== 0 || drop_count !== 0) begin
      n_fail++;
      $display("FAIL wd_after: got cyc=%0d inst=%0d v=%0b drop=%0d want 50 0 0 0",
               cycle_count, inst_count, out_valid, drop_count);
    end
    do_reset();
    idle(49);
    commit(0, 0, 0, 1, 5'd0, 32'h80, 32'h0, 32'h0, 32'h0);
    idle(3);
    n_tests++;
    if (halted !== 1 || timeout !== 0 || cycle_count !== 50 || out_valid !== 1 || out_kind !== 3'd4) begin
      n_fail++;
      $display("FAIL wd_halt_tie: got h=%0b to=%0b cyc=%0d v=%0b k=%0d want 1 0 50 1 4",
               halted, timeout, cycle_count, out_valid, out_kind);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    filter_mode = 0; out_ready = 0;
    for (int i = 0; i < 6; i++) commit(1, 0, 0, 0, 5'(i + 1), 32'(i * 4), 32'(i), 32'h0, 32'h0);
    n_tests++;
    if (out_valid !== 1 || inst_count !== 6) begin
      n_fail++;
      $display("FAIL rm_fill: got v=%0b inst=%0d want 1 6", out_valid, inst_count);
    end
    rst = 1;
    idle(1);
    rst = 0;
    n_tests++;
    if (out_valid !== 0 || cycle_count !== 0 || inst_count !== 0 || drop_count !== 0 ||
        overflow !== 0 || halted !== 0 || timeout !== 0) begin
      n_fail++;
      $display("FAIL rm_cleared: got v=%0b cyc=%0d inst=%0d want 0 0 0", out_valid, cycle_count, inst_count);
    end
    out_ready = 1;
    commit(1, 0, 0, 0, 5'd9, 32'h400, 32'hAB, 32'h0, 32'h0);
    n_tests++;
    if (out_valid !== 1 || out_inum !== 0 || out_pc !== 32'h400) begin
      n_fail++;
      $display("FAIL rm_first: got v=%0b n=%0d pc=%h want 1 0 400", out_valid, out_inum, out_pc);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_filter();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
